// File: rtl/jk_lab_pkg.sv
// Shared definitions for the JK-flip-flop lab blocks: next-state select
// encoding and the JK excitation helper.
package jk_lab_pkg;

    typedef enum logic [1:0] {
        NS_HOLD,
        NS_LOAD,
        NS_UP,
        NS_DOWN
    } ns_sel_t;

    // Returns {J, K} that moves a cell from cur to target; don't-cares resolved to 0.
    function automatic logic [1:0] jk_excite(input logic target, input logic cur);
        return {~cur & target, cur & ~target};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK storage element with synchronous active-high reset.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter stored in a bank of JK cells; this block computes
// the desired next count and drives each cell's J/K from it.
module jk_mod_counter
    import jk_lab_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             load_err,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    // Width-extended modulus so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    ns_sel_t          sel;
    logic [WIDTH-1:0] next_cnt;
    logic             load_oob;
    logic             illegal;

    assign load_oob = ({1'b0, load_val} >= MOD_EXT);
    assign illegal  = ({1'b0, count} >= MOD_EXT);

    always_comb begin
        sel = NS_HOLD;
        if (load) begin
            sel = NS_LOAD;
        end else if (en) begin
            sel = up ? NS_UP : NS_DOWN;
        end
    end

    // An out-of-range count recovers to 0 on the next enabled step.
    always_comb begin
        next_cnt = count;
        unique case (sel)
            NS_LOAD: next_cnt = load_oob ? MAX_CNT : load_val;
            NS_UP:   next_cnt = (illegal || count == MAX_CNT) ? '0 : count + ONE;
            NS_DOWN: begin
                if (illegal) begin
                    next_cnt = '0;
                end else if (count == '0) begin
                    next_cnt = MAX_CNT;
                end else begin
                    next_cnt = count - ONE;
                end
            end
            default: next_cnt = count;
        endcase
    end

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            {j_vec[i], k_vec[i]} = jk_excite(next_cnt[i], count[i]);
        end
    end

    always_comb begin
        tc = en & ~load & ~reset &
             ((up & (count == MAX_CNT)) | (~up & (count == '0)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & load_oob;
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_cell
            jk_cell u_cell (
                .clk   (clk),
                .reset (reset),
                .j     (j_vec[g]),
                .k     (k_vec[g]),
                .q     (count[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: vector table with a scoreboard,
// plus a two-digit cascade rolling 00..99..00.
module tb_jk_mod_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset, en, up, load;
    logic [W-1:0] load_val;
    logic [W-1:0] count, j_vec, k_vec;
    logic         tc, load_err;

    logic         c_reset;
    logic [W-1:0] lo_count, hi_count, lo_j, lo_k, hi_j, hi_k;
    logic         lo_tc, hi_tc, lo_err, hi_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(W), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .count(count), .tc(tc), .load_err(load_err),
        .j_vec(j_vec), .k_vec(k_vec)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(10)) u_lo (
        .clk(clk), .reset(c_reset), .en(1'b1), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(lo_count), .tc(lo_tc), .load_err(lo_err),
        .j_vec(lo_j), .k_vec(lo_k)
    );

    jk_mod_counter #(.WIDTH(W), .MODULUS(10)) u_hi (
        .clk(clk), .reset(c_reset), .en(lo_tc), .up(1'b1), .load(1'b0),
        .load_val(4'd0), .count(hi_count), .tc(hi_tc), .load_err(hi_err),
        .j_vec(hi_j), .k_vec(hi_k)
    );

    typedef struct {
        logic         rst;
        logic         en;
        logic         up;
        logic         ld;
        logic [W-1:0] lv;
        logic [W-1:0] cnt;   // count after the edge
        logic         tc;    // tc before the edge
        logic         err;   // load_err after the edge
    } vec_t;

    typedef struct {
        int           idx;
        logic [W-1:0] cnt;
        logic         err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(logic r, logic e, logic u, logic l, logic [W-1:0] v,
                                logic [W-1:0] c, logic t, logic er);
        vec_t x;
        x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v;
        x.cnt = c; x.tc = t; x.err = er;
        return x;
    endfunction

    task automatic check(string name, int idx, logic [W-1:0] act, logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
        end
    endtask

    task automatic run_vec(int idx, vec_t v, logic [W-1:0] prev);
        exp_t e, got;
        reset = v.rst; en = v.en; up = v.up; load = v.ld; load_val = v.lv;
        e.idx = idx; e.cnt = v.cnt; e.err = v.err;
        sb.push_back(e);
        @(negedge clk);
        check("tc", idx, W'(tc), W'(v.tc));
        if (!v.rst) begin
            check("j_vec", idx, j_vec, ~prev & v.cnt);
            check("k_vec", idx, k_vec, prev & ~v.cnt);
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at vec %0d", idx);
        end else begin
            got = sb.pop_front();
            check("count", got.idx, count, got.cnt);
            check("load_err", got.idx, W'(load_err), W'(got.err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] prev;
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        c_reset = 1'b1;

        // Reset, then count up 12 clocks: tc only while count==9.
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(0, 1, 1, 0, 0, W'((i + 1) % 10), i == 9, 0));
        // Reset, then count down 0,9,...,0,9.
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 11; i++)
            vecs.push_back(mk(0, 1, 0, 0, 0, W'((10 - ((i + 1) % 10)) % 10),
                              (i % 10) == 0, 0));
        // Loads from count 9 with up=1: tc suppressed, errors for >= 10.
        vecs.push_back(mk(0, 1, 1, 1, 5,  5, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 12, 9, 0, 1));
        vecs.push_back(mk(0, 1, 1, 1, 15, 9, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0,  9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 9,  9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 10, 9, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 6,  6, 0, 0));
        // Hold at 6 with direction toggling.
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 6, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 6, 0, 0));
        // Reset wins over load and en.
        vecs.push_back(mk(0, 0, 1, 1, 8,  8, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 3,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 12, 9, 0, 1));
        vecs.push_back(mk(1, 0, 1, 1, 12, 0, 0, 0));
        // Direction changes with no dead cycle.
        vecs.push_back(mk(0, 1, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0));
        // Hold at 9 with up=1 gives no tc; reset at a tc condition forces tc low.
        vecs.push_back(mk(0, 0, 1, 1, 9, 9, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 9, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        prev = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(i, vecs[i], prev);
            prev = vecs[i].cnt;
        end

        // Hand-checked excitation spot values.
        reset = 1'b0; load = 1'b1; load_val = 4'd7; en = 1'b0; up = 1'b1;
        @(posedge clk); #1;
        load = 1'b0; en = 1'b1; up = 1'b1;
        @(negedge clk);
        check("j_at_7_up", 0, j_vec, 4'b1000);
        check("k_at_7_up", 0, k_vec, 4'b0111);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; en = 1'b1; up = 1'b0;
        @(negedge clk);
        check("j_at_0_down", 0, j_vec, 4'b1001);
        check("k_at_0_down", 0, k_vec, 4'b0000);
        check("tc_at_0_down", 0, W'(tc), W'(1));

        // Cascade: 100 clocks after reset roll 00..99 back to 00.
        @(posedge clk); #1;
        c_reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("lo_digit", i, lo_count, W'(i % 10));
            check("hi_digit", i, hi_count, W'(i / 10));
            check("hi_tc", i, W'(hi_tc), W'(i == 99));
            @(posedge clk); #1;
        end
        check("lo_wrap", 100, lo_count, 4'd0);
        check("hi_wrap", 100, hi_count, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
